generic_bram_pipe: RTL and testbench

Second-generation behavioural model of a true dual-port FPGA BRAM, used in benches in place of vendor primitives. It adds the following over the first-generation model:
- a parametrised read-latency pipeline with per-port valid strobes
- byte-lane write enables
- a selectable read/write collision policy
- an optional sequential initialisation engine, which runs after reset and gates both ports through a ready output

---
 rtl/generic_bram_pipe_if.sv | 25 ++
 rtl/generic_bram_pipe.sv | 180 ++++++++++++++++++
 tb/tb_generic_bram_pipe.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/generic_bram_pipe_if.sv
// One port of the dual-port BRAM model.
// The bench or a master drives the request; the memory returns the read data.
interface generic_bram_pipe_if #(
    parameter int WORD_W = 32,
    parameter int BE_N   = 4,
    parameter int ADDR_W = 8
);
    logic              ce;
    logic              rnw;
    logic [BE_N-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] din;
    logic [WORD_W-1:0] dout;
    logic              dvalid;

    modport master (
        output ce, rnw, be, addr, din,
        input  dout, dvalid
    );

    modport slave (
        input  ce, rnw, be, addr, din,
        output dout, dvalid
    );
endinterface

// File: rtl/generic_bram_pipe.sv
// True dual-port BRAM model: byte lanes, read pipeline, collision policy,
// and a post-reset init engine that holds both ports off through ready.
module generic_bram_pipe #(
    parameter int WORD_W       = 32,
    parameter int WORDS_N      = 256,
    parameter int BYTE_W       = 8,
    parameter int RD_LAT       = 1,
    parameter int HOLD_DOUT    = 0,
    parameter int COLLIDE_MODE = 0,
    parameter int INIT_ON_RST  = 1,
    parameter logic [WORD_W-1:0] INIT_VALUE = '0
) (
    input  logic clk,
    input  logic rst,
    output logic ready,
    generic_bram_pipe_if.slave pa,
    generic_bram_pipe_if.slave pb
);
    localparam int BE_N   = WORD_W / BYTE_W;
    localparam int ADDR_W = (WORDS_N > 1) ? $clog2(WORDS_N) : 1;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(WORDS_N - 1);

    if (WORD_W % BYTE_W != 0) begin : g_bad_word_w
        $error("WORD_W must be a multiple of BYTE_W");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("RD_LAT must be in 1..4");
    end

    typedef enum logic [1:0] {
        IDLE_RST = 2'd0,
        INIT     = 2'd1,
        READY    = 2'd2
    } st_t;

    st_t st_q;
    st_t st_d;
    logic [ADDR_W-1:0] cnt;
    logic cnt_last;
    logic init_we;

    logic [WORD_W-1:0] mem [WORDS_N];

    logic              ce   [2];
    logic              rnw  [2];
    logic [BE_N-1:0]   be   [2];
    logic [ADDR_W-1:0] addr [2];
    logic [WORD_W-1:0] din  [2];

    logic              acc;
    logic              inr   [2];
    logic              rd    [2];
    logic              wr    [2];
    logic [BE_N-1:0]   wlane [2];
    logic [WORD_W-1:0] rdata [2];

    logic [RD_LAT-1:0] vld_q  [2];
    logic [RD_LAT-1:0] clr_q  [2];
    logic [WORD_W-1:0] dat_q  [2][RD_LAT];
    logic [WORD_W-1:0] hold_q [2];
    logic [WORD_W-1:0] dout_o [2];
    logic              dv_o   [2];

    assign ce[0]   = pa.ce;
    assign rnw[0]  = pa.rnw;
    assign be[0]   = pa.be;
    assign addr[0] = pa.addr;
    assign din[0]  = pa.din;
    assign ce[1]   = pb.ce;
    assign rnw[1]  = pb.rnw;
    assign be[1]   = pb.be;
    assign addr[1] = pb.addr;
    assign din[1]  = pb.din;

    assign pa.dout   = dout_o[0];
    assign pa.dvalid = dv_o[0];
    assign pb.dout   = dout_o[1];
    assign pb.dvalid = dv_o[1];

    always_ff @(posedge clk) begin
        if (rst) st_q <= IDLE_RST;
        else     st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            IDLE_RST: st_d = (INIT_ON_RST != 0) ? INIT : READY;
            INIT:     st_d = cnt_last ? READY : INIT;
            READY:    st_d = READY;
            default:  st_d = IDLE_RST;
        endcase
    end

    always_comb begin
        ready   = (st_q == READY);
        init_we = (st_q == INIT);
    end

    assign cnt_last = ({1'b0, cnt} == LAST);

    always_ff @(posedge clk) begin
        if (rst || !init_we) cnt <= '0;
        else                 cnt <= cnt + 1'b1;
    end

    // A request in a reset cycle is dropped even if the FSM is still READY.
    assign acc = ready & ~rst;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            inr[p]   = ({1'b0, addr[p]} <= LAST);
            rd[p]    = acc & ce[p] & rnw[p];
            wr[p]    = acc & ce[p] & ~rnw[p];
            wlane[p] = (wr[p] && inr[p]) ? be[p] : '0;
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = inr[p] ? mem[addr[p]] : '0;
            if (COLLIDE_MODE == 0 && inr[p] && addr[1-p] == addr[p]) begin
                for (int i = 0; i < BE_N; i++) begin
                    if (wlane[1-p][i])
                        rdata[p][i*BYTE_W +: BYTE_W] =
                            din[1-p][i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Port A is applied last so it owns lanes both ports enable.
    always_ff @(posedge clk) begin
        if (init_we) mem[cnt] <= INIT_VALUE;
        for (int p = 1; p >= 0; p--) begin
            for (int i = 0; i < BE_N; i++) begin
                if (wlane[p][i])
                    mem[addr[p]][i*BYTE_W +: BYTE_W] <=
                        din[p][i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                vld_q[p]  <= '0;
                clr_q[p]  <= '0;
                hold_q[p] <= '0;
                for (int s = 0; s < RD_LAT; s++) dat_q[p][s] <= '0;
            end else begin
                for (int s = RD_LAT - 1; s > 0; s--) begin
                    vld_q[p][s] <= vld_q[p][s-1];
                    clr_q[p][s] <= clr_q[p][s-1];
                    dat_q[p][s] <= dat_q[p][s-1];
                end
                vld_q[p][0] <= rd[p];
                clr_q[p][0] <= wr[p];
                dat_q[p][0] <= rd[p] ? rdata[p] : '0;
                if (vld_q[p][RD_LAT-1])
                    hold_q[p] <= dat_q[p][RD_LAT-1];
                else if (clr_q[p][RD_LAT-1])
                    hold_q[p] <= '0;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            dv_o[p]   = vld_q[p][RD_LAT-1] & ~rst;
            dout_o[p] = '0;
            if (rst)
                dout_o[p] = '0;
            else if (vld_q[p][RD_LAT-1])
                dout_o[p] = dat_q[p][RD_LAT-1];
            else if (!clr_q[p][RD_LAT-1] && HOLD_DOUT != 0)
                dout_o[p] = hold_q[p];
        end
    end
endmodule

// File: tb/tb_generic_bram_pipe.sv
// Bench for generic_bram_pipe: two configurations share one stimulus stream,
// a reference model queues expected per-port results checked at negedge.
module tb_generic_bram_pipe;
    localparam logic [31:0] IV = 32'hA5A5A5A5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ce_i   [2];
    logic        rnw_i  [2];
    logic [3:0]  be_i   [2];
    logic [3:0]  addr_i [2];
    logic [31:0] din_i  [2];

    generic_bram_pipe_if #(.WORD_W(32), .BE_N(4), .ADDR_W(4)) ia0 ();
    generic_bram_pipe_if #(.WORD_W(32), .BE_N(4), .ADDR_W(4)) ib0 ();
    generic_bram_pipe_if #(.WORD_W(32), .BE_N(4), .ADDR_W(4)) ia1 ();
    generic_bram_pipe_if #(.WORD_W(32), .BE_N(4), .ADDR_W(4)) ib1 ();

    assign ia0.ce = ce_i[0];  assign ia0.rnw = rnw_i[0];
    assign ia0.be = be_i[0];  assign ia0.addr = addr_i[0];
    assign ia0.din = din_i[0];
    assign ib0.ce = ce_i[1];  assign ib0.rnw = rnw_i[1];
    assign ib0.be = be_i[1];  assign ib0.addr = addr_i[1];
    assign ib0.din = din_i[1];
    assign ia1.ce = ce_i[0];  assign ia1.rnw = rnw_i[0];
    assign ia1.be = be_i[0];  assign ia1.addr = addr_i[0];
    assign ia1.din = din_i[0];
    assign ib1.ce = ce_i[1];  assign ib1.rnw = rnw_i[1];
    assign ib1.be = be_i[1];  assign ib1.addr = addr_i[1];
    assign ib1.din = din_i[1];

    logic ready_s [2];

    generic_bram_pipe #(
        .WORD_W(32), .WORDS_N(16), .BYTE_W(8), .RD_LAT(3),
        .HOLD_DOUT(0), .COLLIDE_MODE(0), .INIT_ON_RST(1),
        .INIT_VALUE(IV)
    ) u_dut0 (
        .clk(clk), .rst(rst), .ready(ready_s[0]), .pa(ia0), .pb(ib0)
    );

    generic_bram_pipe #(
        .WORD_W(32), .WORDS_N(12), .BYTE_W(8), .RD_LAT(1),
        .HOLD_DOUT(1), .COLLIDE_MODE(1), .INIT_ON_RST(1),
        .INIT_VALUE(IV)
    ) u_dut1 (
        .clk(clk), .rst(rst), .ready(ready_s[1]), .pa(ia1), .pb(ib1)
    );

    function automatic int wn(input int d);
        return (d == 0) ? 16 : 12;
    endfunction
    function automatic int lat(input int d);
        return (d == 0) ? 3 : 1;
    endfunction
    function automatic bit holdm(input int d);
        return d == 1;
    endfunction
    function automatic bit rfirst(input int d);
        return d == 1;
    endfunction

    function automatic logic [31:0] dout_of(input int d, input int p);
        if (d == 0) return (p == 0) ? ia0.dout : ib0.dout;
        return (p == 0) ? ia1.dout : ib1.dout;
    endfunction
    function automatic logic dv_of(input int d, input int p);
        if (d == 0) return (p == 0) ? ia0.dvalid : ib0.dvalid;
        return (p == 0) ? ia1.dvalid : ib1.dvalid;
    endfunction

    typedef struct {
        int          d;
        int          p;
        int          due;
        bit          clr;
        logic [31:0] data;
    } ev_t;

    ev_t         sbq [$];
    logic [31:0] m    [2][16];
    logic [31:0] hold [2][2];
    int          k    [2];
    int          gcyc = 0;
    bit          started = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at cycle %0d",
                     tag, got, exp, gcyc);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            started = 1;
            sbq.delete();
            for (int d = 0; d < 2; d++) begin
                k[d] = 0;
                for (int a = 0; a < 16; a++) m[d][a] = IV;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (k[d] >= wn(d) + 1) begin
                    for (int p = 0; p < 2; p++) begin
                        ev_t e;
                        int a;
                        int q;
                        logic [31:0] v;
                        if (!ce_i[p]) continue;
                        a = int'(addr_i[p]);
                        q = 1 - p;
                        e.d = d; e.p = p; e.due = gcyc + lat(d);
                        e.clr = !rnw_i[p];
                        v = '0;
                        if (rnw_i[p] && a < wn(d)) begin
                            v = m[d][a];
                            if (!rfirst(d) && ce_i[q] && !rnw_i[q] &&
                                int'(addr_i[q]) == a) begin
                                for (int i = 0; i < 4; i++)
                                    if (be_i[q][i])
                                        v[i*8 +: 8] = din_i[q][i*8 +: 8];
                            end
                        end
                        e.data = v;
                        sbq.push_back(e);
                    end
                    for (int p = 1; p >= 0; p--) begin
                        int a;
                        a = int'(addr_i[p]);
                        if (ce_i[p] && !rnw_i[p] && a < wn(d))
                            for (int i = 0; i < 4; i++)
                                if (be_i[p][i])
                                    m[d][a][i*8 +: 8] = din_i[p][i*8 +: 8];
                    end
                end
                if (k[d] < 1000) k[d]++;
            end
        end
        gcyc++;
    endtask

    task automatic check_step();
        if (!started) return;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("ready%0d", d), 32'(ready_s[d]),
                32'(k[d] >= wn(d) + 1));
            for (int p = 0; p < 2; p++) begin
                logic        ev;
                logic [31:0] ed;
                int          idx;
                string       nm;
                nm = $sformatf("d%0d%s", d, (p == 0) ? "a" : "b");
                ev = 0;
                ed = '0;
                idx = -1;
                if (rst) begin
                    hold[d][p] = '0;
                end else begin
                    foreach (sbq[j])
                        if (sbq[j].d == d && sbq[j].p == p &&
                            sbq[j].due == gcyc) idx = j;
                    if (idx >= 0) begin
                        if (sbq[idx].clr) begin
                            hold[d][p] = '0;
                        end else begin
                            ev = 1;
                            ed = sbq[idx].data;
                            hold[d][p] = ed;
                        end
                        sbq.delete(idx);
                    end else if (holdm(d)) begin
                        ed = hold[d][p];
                    end
                end
                chk({nm, "_dvalid"}, 32'(dv_of(d, p)), 32'(ev));
                chk({nm, "_dout"}, dout_of(d, p), ed);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        check_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int p = 0; p < 2; p++) begin
            ce_i[p] = 0; rnw_i[p] = 1; be_i[p] = '0;
            addr_i[p] = '0; din_i[p] = '0;
        end
    endtask

    task automatic op(input int p, input logic rnw, input int a,
                      input logic [31:0] d, input logic [3:0] be);
        logic [31:0] av;
        av = a;
        ce_i[p] = 1; rnw_i[p] = rnw; addr_i[p] = av[3:0];
        din_i[p] = d; be_i[p] = be;
    endtask

    task automatic rand_ops();
        for (int p = 0; p < 2; p++) begin
            ce_i[p]   = 1'($urandom_range(0, 1));
            rnw_i[p]  = 1'($urandom_range(0, 1));
            be_i[p]   = 4'($urandom);
            addr_i[p] = 4'($urandom_range(0, 15));
            din_i[p]  = $urandom;
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            k[d] = 0;
            for (int p = 0; p < 2; p++) hold[d][p] = '0;
        end
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        repeat (20) tick();

        for (int a = 0; a < 16; a++) begin
            op(0, 1, a, 0, 0); op(1, 1, 15 - a, 0, 0); tick();
        end
        idle(); tick();

        op(0, 0, 5, 32'hDEADBEEF, 4'hF); tick();
        idle(); op(0, 1, 5, 0, 0); tick();
        op(0, 1, 5, 0, 0); tick();
        op(0, 1, 6, 0, 0); tick();
        op(0, 1, 5, 0, 0); tick();
        op(0, 1, 6, 0, 0); tick();
        idle(); repeat (5) tick();

        op(0, 0, 2, 32'h11223344, 4'hF); tick();
        idle(); op(1, 0, 2, 32'hAABBCCDD, 4'b0101); tick();
        idle(); op(1, 1, 2, 0, 0); tick();
        idle(); tick();

        op(0, 0, 7, 32'h0, 4'hF); tick();
        op(0, 0, 7, 32'hFFFF0000, 4'b1100);
        op(1, 0, 7, 32'h12345678, 4'b0110); tick();
        idle(); op(0, 1, 7, 0, 0); tick();
        op(0, 1, 7, 0, 0); op(1, 0, 7, 32'h1, 4'hF); tick();
        idle(); op(0, 1, 7, 0, 0); tick();
        idle(); repeat (4) tick();

        op(0, 0, 3, 32'h55, 4'hF); tick();
        idle(); op(0, 1, 3, 0, 0); tick();
        idle(); repeat (10) tick();
        op(0, 0, 9, 32'h77, 4'hF); tick();
        idle(); repeat (4) tick();

        op(0, 0, 13, 32'h1234, 4'hF); op(1, 1, 13, 0, 0); tick();
        idle(); op(0, 1, 13, 0, 0); op(1, 1, 12, 0, 0); tick();
        idle(); op(0, 0, 4, 32'hCAFE, 4'b0000); tick();
        idle(); op(0, 1, 4, 0, 0); tick();
        idle(); repeat (4) tick();

        repeat (300) begin
            rand_ops(); tick();
        end
        idle(); repeat (5) tick();

        op(0, 1, 5, 0, 0); op(1, 1, 6, 0, 0); tick();
        idle(); rst = 1; tick();
        rst = 0;
        repeat (9) begin
            rand_ops(); tick();
        end
        idle(); op(0, 1, 1, 0, 0); rst = 1; tick();
        rst = 0; idle();
        repeat (20) tick();

        for (int a = 0; a < 16; a++) begin
            op(0, 1, a, 0, 0); op(1, 1, a, 0, 0); tick();
        end
        idle(); repeat (6) tick();

        if (sbq.size() != 0) chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
